// File: rtl/demux_pkg.sv
// ============================================================================
// Module  : demux_pkg
// Brief   : Shared constants and state encoding for the 1-to-8 demux dispatcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int NUM_OUT    = 8;
    localparam int SEL_W      = 3;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_dec3to8.sv
// ============================================================================
// Module  : demux_dec3to8
// Brief   : Combinational 3-to-8 one-hot decoder with enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_dec3to8
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [NUM_OUT-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y = NUM_OUT'(1) << sel;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux8_dispatch_ctrl.sv
// ============================================================================
// Module  : demux8_dispatch_ctrl
// Brief   : Dispatches tagged words to one of 8 valid/ready channels, dropping
//           words whose consumer stalls past TIMEOUT. Option: DEMUX_DROP_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux8_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic [SEL_W-1:0]      in_dest,
    output logic [SEL_W-1:0]      out_sel,
    output logic [DW-1:0]         out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic                  busy,
`ifdef DEMUX_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_count,
`endif
    output logic                  drop_pulse
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_wait_cnt;
    logic [CW-1:0]        w_wait_nxt;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic [DW-1:0]        w_data_nxt;
    logic [NUM_OUT-1:0]   w_valid_nxt;
    logic                 w_drop_nxt;
    logic                 w_sel_ready;

    // out_valid is one-hot on out_sel while in SEND, so masking picks out_ready[out_sel].
    assign w_sel_ready = |(out_ready & out_valid);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = out_sel;
        w_data_nxt  = out_data;
        w_wait_nxt  = r_wait_cnt;
        w_drop_nxt  = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_sel_nxt   = in_dest;
                    w_data_nxt  = in_data;
                    w_wait_nxt  = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                in_ready = w_sel_ready;
                if (w_sel_ready) begin
                    w_wait_nxt = '0;
                    if (in_valid) begin
                        w_sel_nxt  = in_dest;
                        w_data_nxt = in_data;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (TIMEOUT != 0) begin
                    if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
                        w_drop_nxt  = 1'b1;
                        w_wait_nxt  = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_wait_nxt = r_wait_cnt + CW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    demux_dec3to8 u_dec (
        .sel (w_sel_nxt),
        .en  (w_state_nxt == SEND),
        .y   (w_valid_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            out_sel    <= '0;
            out_data   <= '0;
            out_valid  <= '0;
            r_wait_cnt <= '0;
            drop_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            out_sel    <= w_sel_nxt;
            out_data   <= w_data_nxt;
            out_valid  <= w_valid_nxt;
            r_wait_cnt <= w_wait_nxt;
            drop_pulse <= w_drop_nxt;
            busy       <= (w_state_nxt == SEND);
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop_pulse && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux8_dispatch_ctrl.sv
// ============================================================================
// Module  : tb_demux8_dispatch_ctrl
// Brief   : Directed self-checking bench for demux8_dispatch_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux8_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_dest;
    logic [2:0] out_sel;
    logic [7:0] out_data;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic       busy;
    logic       drop_pulse;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux8_dispatch_ctrl #(.DW(8), .TIMEOUT(15), .CW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .out_sel    (out_sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef DEMUX_DROP_CNT_EN
        .drop_count (drop_count),
`endif
        .drop_pulse (drop_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_dest   = 3'd0;
        out_ready = 8'hFF;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h00);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_drop", 32'(drop_pulse), 32'h0);

        // Back-to-back A0..A7 to dest 0..7
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'hA0 + 8'(i);
            in_dest = 3'(i);
            #1;
            chk("b2b_in_ready", 32'(in_ready), 32'h1);
            tick();
            chk("b2b_out_valid", 32'(out_valid), 32'h1 << i);
            chk("b2b_out_data", 32'(out_data), 32'hA0 + 32'(i));
            chk("b2b_out_sel", 32'(out_sel), 32'(i));
            chk("b2b_busy", 32'(busy), 32'h1);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_idle_valid", 32'(out_valid), 32'h00);
        chk("b2b_hold_data", 32'(out_data), 32'hA7);
        chk("b2b_hold_sel", 32'(out_sel), 32'h7);
        chk("b2b_idle_busy", 32'(busy), 32'h0);

        // Stall: dest 3 not ready for 5 cycles
        out_ready = 8'hF7;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_dest   = 3'd3;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(out_valid), 32'h08);
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_drop", 32'(drop_pulse), 32'h0);
            tick();
        end
        out_ready = 8'hFF;
        #1;
        chk("stall_valid6", 32'(out_valid), 32'h08);
        chk("stall_data", 32'(out_data), 32'h5A);
        chk("stall_release_ready", 32'(in_ready), 32'h1);
        tick();
        chk("stall_done_valid", 32'(out_valid), 32'h00);
        chk("stall_done_drop", 32'(drop_pulse), 32'h0);

        // Timeout: dest 6 never ready -> dropped after 15 SEND cycles
        out_ready = 8'hBF;
        in_valid  = 1'b1;
        in_data   = 8'h66;
        in_dest   = 3'd6;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk("to_valid", 32'(out_valid), 32'h40);
            chk("to_drop_early", 32'(drop_pulse), 32'h0);
            tick();
        end
        chk("to_drop_pulse", 32'(drop_pulse), 32'h1);
        chk("to_idle_valid", 32'(out_valid), 32'h00);
        chk("to_idle_busy", 32'(busy), 32'h0);
        chk("to_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("to_drop_single", 32'(drop_pulse), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
        chk("to_drop_count", 32'(drop_count), 32'h1);
`endif
        out_ready = 8'hFF;

        // Mid-stall reset on dest 2
        out_ready = 8'hFB;
        in_valid  = 1'b1;
        in_data   = 8'h22;
        in_dest   = 3'd2;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid_valid_pre", 32'(out_valid), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid_async", 32'(out_valid), 32'h00);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_sel", 32'(out_sel), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mid_nodrop", 32'(drop_pulse), 32'h0);
        chk("rst_mid_idle", 32'(out_valid), 32'h00);
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_data   = 8'h44;
        in_dest   = 3'd4;
        tick();
        in_valid = 1'b0;
        chk("rst_after_valid", 32'(out_valid), 32'h10);
        chk("rst_after_data", 32'(out_data), 32'h44);
        tick();
        chk("rst_after_done", 32'(out_valid), 32'h00);

        // Ready coincides with timeout cycle on dest 1
        out_ready = 8'hFD;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        in_dest   = 3'd1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
        end
        chk("co_valid15", 32'(out_valid), 32'h02);
        out_ready = 8'hFF;
        #1;
        chk("co_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("co_valid_done", 32'(out_valid), 32'h00);
        chk("co_no_drop", 32'(drop_pulse), 32'h0);
        chk("co_busy", 32'(busy), 32'h0);
        tick();
        chk("co_no_drop_late", 32'(drop_pulse), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
